id_exec_ctrl: RTL and testbench
===============================

Name: id_exec_ctrl

Overview:
- Decode/execute sequencer directly downstream of the instruction-fetch controller.
- Waits for the fetch stage's IR-ready pulse, captures the 16-bit instruction and decodes it.
- Sequences the shared-bus register transfers (register file, ALU latches, MAR/MDR, PC) to execute it, including the memory MFC handshake.
- When done, pulses fetch_start so the fetch stage starts the next fetch.

Parameters:
- IW, 16, instruction width; IR and immediate bus width.
- RAW, 4, register-file address width.
- MFC_TIMEOUT, 255, cycles allowed waiting for mfc before a bus error.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high.
- ir_valid  in  1  one-cycle pulse: ir holds a new instruction.
- ir  in  IW  instruction: op=ir[15:12], rd=ir[11:8], rs=ir[7:4], imm8=ir[7:0].
- mfc  in  1  memory function complete.
- fetch_start  out  1  request next fetch (one-cycle pulse).
- rf_out_en  out  1  register file drives bus.
- rf_rd_addr  out  RAW  register driving bus.
- rf_we  out  1  write bus value into rf_wr_addr.
- rf_wr_addr  out  RAW  always the latched rd.
- imm_out_en  out  1  drive imm_data onto bus.
- imm_data  out  IW  zero-extended imm8.
- alu_a_load  out  1  latch bus into ALU A.
- alu_res_load  out  1  latch ALU(A, bus) result.
- alu_op  out  2  00 add, 01 sub, 10 and, 11 or.
- alu_out_en  out  1  ALU result latch drives bus.
- mar_load  out  1  latch bus into MAR.
- mdr_bus_load  out  1  latch bus into MDR.
- mdr_read_en  out  1  latch memory data into MDR.
- mdr_out_en  out  1  MDR drives bus.
- mem_en  out  1  memory cycle active.
- r_w  out  1  1 = read, 0 = write.
- pc_load  out  1  load PC from bus.
- busy  out  1  not in IDLE/HALT/ERR.
- illegal  out  1  one-cycle pulse on an undefined opcode.
- halted  out  1  HALT executed.
- bus_err  out  1  MFC timeout.

Behaviour:
- Moore FSM: all outputs decode from the current state plus the latched instruction register (instr).
- At most one bus driver is asserted in any state.
- Reset (async, any time, including mid-memory-cycle):
  - state = BOOT, instr = 0, timeout counter = 0.
  - Every output is 0 except fetch_start = 1; mem_en drops immediately.
- BOOT -> IDLE unconditionally, so the first fetch starts on the first edge after reset.
- IDLE: on ir_valid, instr <= ir, go to DECODE. ir_valid in any other state is ignored.
- DECODE branches on op:
  - 0 NOP -> DONE.
  - 1-4 ADD/SUB/AND/OR -> EXA.
  - 5 LDI -> LDI.
  - 6 LD -> MADR.
  - 7 ST -> MADR.
  - 8 JMP -> JMP.
  - 9 HALT -> HALT.
  - else -> ILL.
- EXA: rf_out_en, rf_rd_addr = rd, alu_a_load -> EXB.
- EXB: rf_out_en, rf_rd_addr = rs, alu_res_load, alu_op = op - 1 -> WB.
- WB: alu_out_en, rf_we -> DONE.
  - rd == rs is legal; A was latched earlier.
- LDI: imm_out_en, rf_we -> DONE.
- MADR: rf_out_en, rf_rd_addr = rs, mar_load -> MRD (LD) or SDAT (ST).
- MRD: mem_en = 1, r_w = 1. On mfc -> MCAP; otherwise count.
- MCAP: mdr_read_en -> MWB.
- MWB: mdr_out_en, rf_we -> DONE.
- SDAT: rf_out_en, rf_rd_addr = rd, mdr_bus_load -> MWR.
- MWR: mem_en = 1, r_w = 0. On mfc -> DONE; otherwise count.
- Timeout:
  - The counter clears on entering MRD/MWR and increments each cycle without mfc.
  - When it reaches MFC_TIMEOUT -> ERR.
  - If mfc is high in the same cycle the limit is reached, mfc wins.
- ERR: bus_err = 1, mem_en = 0, no fetch_start. Exits only on reset.
- JMP: rf_out_en, rf_rd_addr = rs, pc_load -> DONE.
- ILL: illegal = 1 for one cycle -> DONE; the instruction is skipped.
- HALT: halted = 1, stays until reset, no fetch_start.
- DONE: fetch_start = 1 for one cycle -> IDLE.
- busy = 1 in every state except IDLE, HALT and ERR.
- Latency, counted in cycles from the ir_valid edge to the fetch_start cycle:
  - NOP 2, LDI 3, JMP 3, ALU 5, ILL 3.
  - LD 6 + k, ST 5 + k, where k = cycles of mfc wait beyond the first.
- r_w = 0 outside memory states. rf_rd_addr and rf_wr_addr = 0 when not in use.

Test Plan:
- Reset release -> fetch_start = 1 during reset and on the first cycle after; all other outputs 0. Then ir_valid with ir = 16'h1230 (ADD r2, r3) -> EXA with rd_addr 2, EXB with rd_addr 3 and alu_op 00, WB with wr_addr 2, fetch_start 5 cycles after ir_valid.
- ir = 16'h5A7F (LDI r10, 0x7F) -> imm_data = 16'h007F, imm_out_en and rf_we with wr_addr 10 in the same cycle, fetch_start 3 cycles after ir_valid.
- ir = 16'h6140 (LD r1, [r4]), mfc raised after 3 wait cycles -> MADR, mem_en = 1 and r_w = 1 for 4 cycles, then mdr_read_en, then mdr_out_en + rf_we with wr_addr 1; fetch_start at cycle 9. Repeat as ST 16'h7140: rd_addr 1 with mdr_bus_load, r_w = 0 during the wait.
- LD with mfc never asserted, MFC_TIMEOUT = 4 -> bus_err = 1 after 4 MRD cycles, mem_en = 0, no fetch_start. Repeat with mfc on the 4th cycle -> completes normally, bus_err = 0.
- ir = 16'hF000 -> illegal pulses exactly 1 cycle, then fetch_start. ir = 16'h9000 -> halted = 1, busy = 0; further ir_valid is ignored.
- Assert reset during an MRD wait -> mem_en = 0 asynchronously, state BOOT, fetch_start = 1 after release. An ir_valid pulse while busy is not captured.

Source files
------------

// File: rtl/id_exec_ctrl.sv
// id_exec_ctrl -- decode/execute sequencer for a single shared-bus datapath.
// Rev 1.0 -- initial release.
`default_nettype none

module id_exec_ctrl #(
  parameter int IW          = 16,
  parameter int RAW         = 4,
  parameter int MFC_TIMEOUT = 255
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           ir_valid,
  input  logic [IW-1:0]  ir,
  input  logic           mfc,
  output logic           fetch_start,
  output logic           rf_out_en,
  output logic [RAW-1:0] rf_rd_addr,
  output logic           rf_we,
  output logic [RAW-1:0] rf_wr_addr,
  output logic           imm_out_en,
  output logic [IW-1:0]  imm_data,
  output logic           alu_a_load,
  output logic           alu_res_load,
  output logic [1:0]     alu_op,
  output logic           alu_out_en,
  output logic           mar_load,
  output logic           mdr_bus_load,
  output logic           mdr_read_en,
  output logic           mdr_out_en,
  output logic           mem_en,
  output logic           r_w,
  output logic           pc_load,
  output logic           busy,
  output logic           illegal,
  output logic           halted,
  output logic           bus_err
);

  localparam int             CW      = $clog2(MFC_TIMEOUT + 1);
  localparam logic [CW-1:0]  C_LIMIT = CW'(MFC_TIMEOUT - 1);

  typedef enum logic [4:0] {
    S_BOOT, S_IDLE, S_DECODE, S_EXA, S_EXB, S_WB, S_LDI, S_MADR, S_MRD,
    S_MCAP, S_MWB, S_SDAT, S_MWR, S_JMP, S_ILL, S_HALT, S_ERR, S_DONE
  } state_t;

  state_t          state_q, state_d;
  logic [IW-1:0]   instr_q, instr_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [3:0]      op_q, op_n;
  logic [RAW-1:0]  rd_n, rs_n;

  logic fetch_start_q, fetch_start_d, rf_out_en_q, rf_out_en_d, rf_we_q, rf_we_d;
  logic imm_out_en_q, imm_out_en_d, alu_a_load_q, alu_a_load_d;
  logic alu_res_load_q, alu_res_load_d, alu_out_en_q, alu_out_en_d;
  logic mar_load_q, mar_load_d, mdr_bus_load_q, mdr_bus_load_d;
  logic mdr_read_en_q, mdr_read_en_d, mdr_out_en_q, mdr_out_en_d;
  logic mem_en_q, mem_en_d, r_w_q, r_w_d, pc_load_q, pc_load_d, busy_q, busy_d;
  logic illegal_q, illegal_d, halted_q, halted_d, bus_err_q, bus_err_d;
  logic [RAW-1:0] rf_rd_addr_q, rf_rd_addr_d, rf_wr_addr_q, rf_wr_addr_d;
  logic [IW-1:0]  imm_data_q, imm_data_d;
  logic [1:0]     alu_op_q, alu_op_d;

  assign op_q = instr_q[15:12];

  always_comb begin
    state_d = state_q;
    instr_d = instr_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_BOOT:   state_d = S_IDLE;
      S_IDLE: begin
        if (ir_valid) begin
          instr_d = ir;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        case (op_q)
          4'd0:                   state_d = S_DONE;
          4'd1, 4'd2, 4'd3, 4'd4: state_d = S_EXA;
          4'd5:                   state_d = S_LDI;
          4'd6, 4'd7:             state_d = S_MADR;
          4'd8:                   state_d = S_JMP;
          4'd9:                   state_d = S_HALT;
          default:                state_d = S_ILL;
        endcase
      end
      S_EXA:    state_d = S_EXB;
      S_EXB:    state_d = S_WB;
      S_MADR: begin
        cnt_d   = '0;
        state_d = (op_q == 4'd7) ? S_SDAT : S_MRD;
      end
      S_SDAT: begin
        cnt_d   = '0;
        state_d = S_MWR;
      end
      // mfc takes priority over the timeout in the cycle the limit is hit
      S_MRD, S_MWR: begin
        if (mfc)                  state_d = (state_q == S_MRD) ? S_MCAP : S_DONE;
        else if (cnt_q == C_LIMIT) state_d = S_ERR;
        else                      cnt_d = cnt_q + 1'b1;
      end
      S_MCAP:   state_d = S_MWB;
      S_WB, S_LDI, S_MWB, S_JMP, S_ILL: state_d = S_DONE;
      S_HALT, S_ERR: state_d = state_q;
      S_DONE:   state_d = S_IDLE;
      default:  state_d = S_BOOT;
    endcase
  end

  // Outputs are decoded from the next state so they come straight off flops.
  assign op_n = instr_d[15:12];
  assign rd_n = RAW'(instr_d[11:8]);
  assign rs_n = RAW'(instr_d[7:4]);

  always_comb begin
    fetch_start_d = 1'b0; rf_out_en_d = 1'b0; rf_rd_addr_d = '0; rf_we_d = 1'b0;
    rf_wr_addr_d = '0; imm_out_en_d = 1'b0; imm_data_d = '0; alu_a_load_d = 1'b0;
    alu_res_load_d = 1'b0; alu_op_d = 2'b00; alu_out_en_d = 1'b0; mar_load_d = 1'b0;
    mdr_bus_load_d = 1'b0; mdr_read_en_d = 1'b0; mdr_out_en_d = 1'b0; mem_en_d = 1'b0;
    r_w_d = 1'b0; pc_load_d = 1'b0; illegal_d = 1'b0; halted_d = 1'b0; bus_err_d = 1'b0;
    busy_d = !(state_d inside {S_BOOT, S_IDLE, S_HALT, S_ERR});
    case (state_d)
      S_BOOT, S_DONE: fetch_start_d = 1'b1;
      S_EXA:  begin rf_out_en_d = 1'b1; rf_rd_addr_d = rd_n; alu_a_load_d = 1'b1; end
      S_EXB:  begin
        rf_out_en_d = 1'b1; rf_rd_addr_d = rs_n; alu_res_load_d = 1'b1;
        alu_op_d = op_n[1:0] - 2'd1;
      end
      S_WB:   begin alu_out_en_d = 1'b1; rf_we_d = 1'b1; rf_wr_addr_d = rd_n; end
      S_LDI:  begin
        imm_out_en_d = 1'b1; imm_data_d = {{(IW-8){1'b0}}, instr_d[7:0]};
        rf_we_d = 1'b1; rf_wr_addr_d = rd_n;
      end
      S_MADR: begin rf_out_en_d = 1'b1; rf_rd_addr_d = rs_n; mar_load_d = 1'b1; end
      S_MRD:  begin mem_en_d = 1'b1; r_w_d = 1'b1; end
      S_MCAP: mdr_read_en_d = 1'b1;
      S_MWB:  begin mdr_out_en_d = 1'b1; rf_we_d = 1'b1; rf_wr_addr_d = rd_n; end
      S_SDAT: begin rf_out_en_d = 1'b1; rf_rd_addr_d = rd_n; mdr_bus_load_d = 1'b1; end
      S_MWR:  mem_en_d = 1'b1;
      S_JMP:  begin rf_out_en_d = 1'b1; rf_rd_addr_d = rs_n; pc_load_d = 1'b1; end
      S_ILL:  illegal_d = 1'b1;
      S_HALT: halted_d = 1'b1;
      S_ERR:  bus_err_d = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_BOOT; instr_q <= '0; cnt_q <= '0;
      fetch_start_q <= 1'b1; rf_out_en_q <= 1'b0; rf_rd_addr_q <= '0; rf_we_q <= 1'b0;
      rf_wr_addr_q <= '0; imm_out_en_q <= 1'b0; imm_data_q <= '0; alu_a_load_q <= 1'b0;
      alu_res_load_q <= 1'b0; alu_op_q <= 2'b00; alu_out_en_q <= 1'b0; mar_load_q <= 1'b0;
      mdr_bus_load_q <= 1'b0; mdr_read_en_q <= 1'b0; mdr_out_en_q <= 1'b0; mem_en_q <= 1'b0;
      r_w_q <= 1'b0; pc_load_q <= 1'b0; busy_q <= 1'b0; illegal_q <= 1'b0;
      halted_q <= 1'b0; bus_err_q <= 1'b0;
    end else begin
      state_q <= state_d; instr_q <= instr_d; cnt_q <= cnt_d;
      fetch_start_q <= fetch_start_d; rf_out_en_q <= rf_out_en_d;
      rf_rd_addr_q <= rf_rd_addr_d; rf_we_q <= rf_we_d; rf_wr_addr_q <= rf_wr_addr_d;
      imm_out_en_q <= imm_out_en_d; imm_data_q <= imm_data_d; alu_a_load_q <= alu_a_load_d;
      alu_res_load_q <= alu_res_load_d; alu_op_q <= alu_op_d; alu_out_en_q <= alu_out_en_d;
      mar_load_q <= mar_load_d; mdr_bus_load_q <= mdr_bus_load_d;
      mdr_read_en_q <= mdr_read_en_d; mdr_out_en_q <= mdr_out_en_d; mem_en_q <= mem_en_d;
      r_w_q <= r_w_d; pc_load_q <= pc_load_d; busy_q <= busy_d; illegal_q <= illegal_d;
      halted_q <= halted_d; bus_err_q <= bus_err_d;
    end
  end

  assign fetch_start  = fetch_start_q;
  assign rf_out_en    = rf_out_en_q;
  assign rf_rd_addr   = rf_rd_addr_q;
  assign rf_we        = rf_we_q;
  assign rf_wr_addr   = rf_wr_addr_q;
  assign imm_out_en   = imm_out_en_q;
  assign imm_data     = imm_data_q;
  assign alu_a_load   = alu_a_load_q;
  assign alu_res_load = alu_res_load_q;
  assign alu_op       = alu_op_q;
  assign alu_out_en   = alu_out_en_q;
  assign mar_load     = mar_load_q;
  assign mdr_bus_load = mdr_bus_load_q;
  assign mdr_read_en  = mdr_read_en_q;
  assign mdr_out_en   = mdr_out_en_q;
  assign mem_en       = mem_en_q;
  assign r_w          = r_w_q;
  assign pc_load      = pc_load_q;
  assign busy         = busy_q;
  assign illegal      = illegal_q;
  assign halted       = halted_q;
  assign bus_err      = bus_err_q;

endmodule

`default_nettype wire

// File: tb/tb_id_exec_ctrl.sv
// tb_id_exec_ctrl -- directed and randomized checks of id_exec_ctrl against a per-instruction trace model.
`default_nettype none

module tb_id_exec_ctrl;

  localparam int TO = 4;

  typedef struct packed {
    logic fetch_start; logic rf_out_en; logic [3:0] rf_rd_addr; logic rf_we;
    logic [3:0] rf_wr_addr; logic imm_out_en; logic [15:0] imm_data;
    logic alu_a_load; logic alu_res_load; logic [1:0] alu_op; logic alu_out_en;
    logic mar_load; logic mdr_bus_load; logic mdr_read_en; logic mdr_out_en;
    logic mem_en; logic r_w; logic pc_load; logic busy; logic illegal;
    logic halted; logic bus_err;
  } outs_t;

  logic clk, reset, ir_valid, mfc;
  logic [15:0] ir;
  logic fetch_start, rf_out_en, rf_we, imm_out_en, alu_a_load, alu_res_load, alu_out_en;
  logic mar_load, mdr_bus_load, mdr_read_en, mdr_out_en, mem_en, r_w, pc_load;
  logic busy, illegal, halted, bus_err;
  logic [3:0] rf_rd_addr, rf_wr_addr;
  logic [15:0] imm_data;
  logic [1:0] alu_op;
  outs_t obs;

  int checks = 0;
  int errors = 0;
  outs_t expq[$];
  bit term;

  id_exec_ctrl #(.IW(16), .RAW(4), .MFC_TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .ir_valid(ir_valid), .ir(ir), .mfc(mfc),
    .fetch_start(fetch_start), .rf_out_en(rf_out_en), .rf_rd_addr(rf_rd_addr),
    .rf_we(rf_we), .rf_wr_addr(rf_wr_addr), .imm_out_en(imm_out_en), .imm_data(imm_data),
    .alu_a_load(alu_a_load), .alu_res_load(alu_res_load), .alu_op(alu_op),
    .alu_out_en(alu_out_en), .mar_load(mar_load), .mdr_bus_load(mdr_bus_load),
    .mdr_read_en(mdr_read_en), .mdr_out_en(mdr_out_en), .mem_en(mem_en), .r_w(r_w),
    .pc_load(pc_load), .busy(busy), .illegal(illegal), .halted(halted), .bus_err(bus_err)
  );

  assign obs = {fetch_start, rf_out_en, rf_rd_addr, rf_we, rf_wr_addr, imm_out_en, imm_data,
                alu_a_load, alu_res_load, alu_op, alu_out_en, mar_load, mdr_bus_load,
                mdr_read_en, mdr_out_en, mem_en, r_w, pc_load, busy, illegal, halted, bus_err};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input outs_t exp, input string tag, input int cyc);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, obs, exp);
    end
  endtask

  // Expected per-cycle outputs from the ir_valid edge onward, for an instruction
  // whose memory access sees mfc after k extra wait cycles.
  task automatic build(input logic [15:0] instr, input int k);
    outs_t b, e;
    logic [3:0] op, rd, rs;
    int n;
    expq.delete();
    term = 1'b0;
    op = instr[15:12]; rd = instr[11:8]; rs = instr[7:4];
    b = '0; b.busy = 1'b1;
    expq.push_back(b);
    if (op >= 4'd1 && op <= 4'd4) begin
      e = b; e.rf_out_en = 1; e.rf_rd_addr = rd; e.alu_a_load = 1; expq.push_back(e);
      e = b; e.rf_out_en = 1; e.rf_rd_addr = rs; e.alu_res_load = 1;
      e.alu_op = 2'(op - 4'd1); expq.push_back(e);
      e = b; e.alu_out_en = 1; e.rf_we = 1; e.rf_wr_addr = rd; expq.push_back(e);
    end else if (op == 4'd5) begin
      e = b; e.imm_out_en = 1; e.imm_data = {8'h00, instr[7:0]};
      e.rf_we = 1; e.rf_wr_addr = rd; expq.push_back(e);
    end else if (op == 4'd6 || op == 4'd7) begin
      e = b; e.rf_out_en = 1; e.rf_rd_addr = rs; e.mar_load = 1; expq.push_back(e);
      if (op == 4'd7) begin
        e = b; e.rf_out_en = 1; e.rf_rd_addr = rd; e.mdr_bus_load = 1; expq.push_back(e);
      end
      n = (k + 1 < TO) ? k + 1 : TO;
      for (int i = 0; i < n; i++) begin
        e = b; e.mem_en = 1; e.r_w = (op == 4'd6); expq.push_back(e);
      end
      if (k + 1 > TO) begin
        e = '0; e.bus_err = 1;
        repeat (3) expq.push_back(e);
        term = 1'b1;
      end else if (op == 4'd6) begin
        e = b; e.mdr_read_en = 1; expq.push_back(e);
        e = b; e.mdr_out_en = 1; e.rf_we = 1; e.rf_wr_addr = rd; expq.push_back(e);
      end
    end else if (op == 4'd8) begin
      e = b; e.rf_out_en = 1; e.rf_rd_addr = rs; e.pc_load = 1; expq.push_back(e);
    end else if (op == 4'd9) begin
      e = '0; e.halted = 1;
      repeat (3) expq.push_back(e);
      term = 1'b1;
    end else if (op != 4'd0) begin
      e = b; e.illegal = 1; expq.push_back(e);
    end
    if (!term) begin
      e = b; e.fetch_start = 1; expq.push_back(e);
    end
  endtask

  task automatic run(input logic [15:0] instr, input int k, input int limit,
                     input bit junk, input string tag);
    int memcnt, n;
    build(instr, k);
    @(posedge clk); #1;
    chk('0, {tag, "_idle"}, -1);
    ir = instr; ir_valid = 1'b1; mfc = 1'b0;
    memcnt = 0;
    n = (limit < expq.size()) ? limit : expq.size();
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      if (junk) begin
        ir_valid = 1'($urandom_range(0, 1)); ir = 16'($urandom);
      end else ir_valid = 1'b0;
      if (expq[i].mem_en) begin
        memcnt++;
        mfc = (memcnt == k + 1);
      end else mfc = junk ? 1'($urandom_range(0, 1)) : 1'b0;
      @(negedge clk);
      chk(expq[i], tag, i);
    end
    ir_valid = 1'b0; mfc = 1'b0;
  endtask

  task automatic do_reset(input string tag);
    outs_t bv;
    bv = '0; bv.fetch_start = 1'b1;
    ir_valid = 1'b0; mfc = 1'b0; reset = 1'b1;
    #2;
    chk(bv, {tag, "_async"}, 0);
    @(negedge clk); reset = 1'b0; #1;
    chk(bv, {tag, "_release"}, 0);
  endtask

  initial begin
    logic [15:0] ri;
    reset = 1'b0; ir = '0; ir_valid = 1'b0; mfc = 1'b0;
    #3;
    do_reset("reset");
    run(16'h1230, 0, 99, 0, "add");
    run(16'h5A7F, 0, 99, 0, "ldi");
    run(16'h6140, 3, 99, 0, "ld_wait3");
    run(16'h7140, 3, 99, 0, "st_wait3");
    run(16'h0000, 0, 99, 0, "nop");
    run(16'h2120, 0, 99, 0, "sub");
    run(16'h3340, 0, 99, 0, "and");
    run(16'h4550, 0, 99, 0, "or");
    run(16'h1330, 0, 99, 0, "add_rd_eq_rs");
    run(16'h8050, 0, 99, 0, "jmp");
    run(16'hF000, 0, 99, 0, "illegal");
    run(16'h6140, 0, 99, 0, "ld_nowait");
    run(16'h7140, 0, 99, 0, "st_nowait");
    run(16'h6140, 50, 99, 1, "ld_timeout");
    do_reset("after_err");
    run(16'h7140, 50, 99, 1, "st_timeout");
    do_reset("after_st_err");
    run(16'h9000, 0, 99, 1, "halt");
    do_reset("after_halt");
    run(16'h6230, 50, 4, 0, "ld_abort");
    do_reset("mid_mrd");
    run(16'h5A7F, 0, 99, 0, "ldi_after_abort");
    for (int t = 0; t < 150; t++) begin
      ri = 16'($urandom);
      if ($urandom_range(0, 2) == 0) ri[15:12] = 4'($urandom_range(6, 7));
      run(ri, $urandom_range(0, 5), 99, 1, "rand");
      if (term) do_reset("rand_reset");
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
